tx_sequencer: RTL and testbench

TX_SEQUENCER -- requirements
Module: tx_sequencer

---
 rtl/tx_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_tx_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_sequencer.sv
// Backscatter reply sequencer: T1 wait, preamble, RN16 or PC+EPC payload, CRC-16 and end bit.
// Serial outputs are registered and aligned with the state they belong to.
module tx_sequencer #(
    parameter int unsigned T1_CYCLES = 8,
    parameter logic [5:0]  PREAMBLE  = 6'b101011,
    parameter int unsigned EPC_BITS  = 112
) (
    input  logic        txclk,
    input  logic        reset_n,
    input  logic        req_rn16,
    input  logic        req_epc,
    input  logic        abort,
    input  logic [15:0] rn16,
    input  logic        epcbitin,
    input  logic        epcdonein,
    output logic        epc_reset,
    output logic        epc_clk_en,
    output logic        txbit,
    output logic        txvalid,
    output logic        busy,
    output logic        txdone,
    output logic        epc_err
);

    localparam int unsigned T1           = (T1_CYCLES < 2) ? 2 : T1_CYCLES;
    localparam logic [6:0]  T1_LAST      = 7'(T1 - 1);
    localparam logic [6:0]  EPC_LAST     = 7'(EPC_BITS - 1);
    localparam logic [6:0]  EPC_CAP_LAST = 7'(EPC_BITS - 2);
    localparam logic [6:0]  RN_LAST      = 7'd15;
    localparam logic [15:0] CRC_POLY     = 16'h1021;
    localparam logic [15:0] CRC_PRESET   = 16'hFFFF;

    typedef enum logic [2:0] {
        StIdle, StWaitT1, StPreamble, StPayload, StCrc, StEndbit, StDone
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  cnt_q, cnt_d;
    logic        is_epc_q, is_epc_d;
    logic [15:0] rn_q, rn_d;
    logic [15:0] crc_q, crc_d;
    logic        txbit_q, txbit_d;
    logic        txvalid_q, txvalid_d;
    logic        txdone_q, txdone_d;
    logic        err_q, err_d;

    logic        accept;
    logic        capture;
    logic        cap_last;
    logic        prime;
    logic [6:0]  pay_last;

    assign accept   = (state_q == StIdle) && !abort && (req_epc || req_rn16);
    assign pay_last = is_epc_q ? EPC_LAST : RN_LAST;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 7'd1;
        is_epc_d  = is_epc_q;
        rn_d      = rn_q;
        crc_d     = crc_q;
        txbit_d   = 1'b0;
        txvalid_d = 1'b0;
        txdone_d  = 1'b0;
        err_d     = err_q;
        capture   = 1'b0;
        cap_last  = 1'b0;
        prime     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = 7'd0;
                if (accept) begin
                    state_d  = StWaitT1;
                    is_epc_d = req_epc;
                    rn_d     = rn16;
                    crc_d    = CRC_PRESET;
                end
            end
            StWaitT1: begin
                // One enable on entry loads the source's top index before the first capture.
                prime = is_epc_q && (cnt_q == 7'd0);
                if (cnt_q == T1_LAST) begin
                    state_d   = StPreamble;
                    cnt_d     = 7'd0;
                    txvalid_d = 1'b1;
                    txbit_d   = PREAMBLE[5];
                end
            end
            StPreamble: begin
                txvalid_d = 1'b1;
                if (cnt_q == 7'd5) begin
                    state_d = StPayload;
                    cnt_d   = 7'd0;
                    if (is_epc_q) begin
                        capture = 1'b1;
                        txbit_d = epcbitin;
                    end else begin
                        txbit_d = rn_q[15];
                        rn_d    = {rn_q[14:0], 1'b0};
                    end
                end else begin
                    txbit_d = PREAMBLE[3'd4 - cnt_q[2:0]];
                end
            end
            StPayload: begin
                txvalid_d = 1'b1;
                if (cnt_q == pay_last) begin
                    cnt_d = 7'd0;
                    if (is_epc_q) begin
                        state_d = StCrc;
                        txbit_d = ~crc_q[15];
                        crc_d   = {crc_q[14:0], 1'b0};
                    end else begin
                        state_d = StEndbit;
                        txbit_d = 1'b1;
                    end
                end else if (is_epc_q) begin
                    capture  = 1'b1;
                    cap_last = (cnt_q == EPC_CAP_LAST);
                    txbit_d  = epcbitin;
                end else begin
                    txbit_d = rn_q[15];
                    rn_d    = {rn_q[14:0], 1'b0};
                end
            end
            StCrc: begin
                txvalid_d = 1'b1;
                if (cnt_q == 7'd15) begin
                    state_d = StEndbit;
                    cnt_d   = 7'd0;
                    txbit_d = 1'b1;
                end else begin
                    txbit_d = ~crc_q[15];
                    crc_d   = {crc_q[14:0], 1'b0};
                end
            end
            StEndbit: begin
                state_d  = StDone;
                cnt_d    = 7'd0;
                txdone_d = 1'b1;
            end
            StDone: begin
                state_d  = StIdle;
                cnt_d    = 7'd0;
                is_epc_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 7'd0;
            end
        endcase

        if (capture) begin
            crc_d = {crc_q[14:0], 1'b0} ^ ((crc_q[15] ^ epcbitin) ? CRC_POLY : 16'h0000);
            if (cap_last && !epcdonein) begin
                err_d = 1'b1;
            end
        end

        if ((state_q != StIdle) && abort) begin
            state_d   = StIdle;
            cnt_d     = 7'd0;
            is_epc_d  = 1'b0;
            rn_d      = 16'h0000;
            crc_d     = CRC_PRESET;
            txbit_d   = 1'b0;
            txvalid_d = 1'b0;
            txdone_d  = 1'b0;
            err_d     = err_q;
            capture   = 1'b0;
            cap_last  = 1'b0;
            prime     = 1'b0;
        end
    end

    always_ff @(posedge txclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= 7'd0;
            is_epc_q  <= 1'b0;
            rn_q      <= 16'h0000;
            crc_q     <= CRC_PRESET;
            txbit_q   <= 1'b0;
            txvalid_q <= 1'b0;
            txdone_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_epc_q  <= is_epc_d;
            rn_q      <= rn_d;
            crc_q     <= crc_d;
            txbit_q   <= txbit_d;
            txvalid_q <= txvalid_d;
            txdone_q  <= txdone_d;
            err_q     <= err_d;
        end
    end

    // Source leaves reset in the accepting cycle so the prime enable lands on a live source.
    assign epc_reset  = !((reset_n && accept && req_epc) ||
                          (is_epc_q && (state_q != StIdle) && (state_q != StDone)));
    assign epc_clk_en = prime || (capture && !cap_last);
    assign txbit      = txbit_q;
    assign txvalid    = txvalid_q;
    assign busy       = (state_q != StIdle);
    assign txdone     = txdone_q;
    assign epc_err    = err_q;

endmodule

// File: tb/tb_tx_sequencer.sv
// Randomised bench for tx_sequencer: a behavioural EPC source plus a reply model built from
// the preamble/payload/CRC rules, compared bit by bit against the serial output.
module tb_tx_sequencer;

    localparam int T1_CYCLES = 8;
    localparam logic [5:0] PREAMBLE = 6'b101011;
    localparam int EPC_BITS = 112;

    logic        txclk = 1'b0;
    logic        reset_n;
    logic        req_rn16, req_epc, abort;
    logic [15:0] rn16;
    logic        epcbitin, epcdonein;
    logic        epc_reset, epc_clk_en, txbit, txvalid, busy, txdone, epc_err;

    int n_cmp = 0;
    int n_err = 0;

    tx_sequencer #(
        .T1_CYCLES(T1_CYCLES),
        .PREAMBLE (PREAMBLE),
        .EPC_BITS (EPC_BITS)
    ) dut (
        .txclk     (txclk),
        .reset_n   (reset_n),
        .req_rn16  (req_rn16),
        .req_epc   (req_epc),
        .abort     (abort),
        .rn16      (rn16),
        .epcbitin  (epcbitin),
        .epcdonein (epcdonein),
        .epc_reset (epc_reset),
        .epc_clk_en(epc_clk_en),
        .txbit     (txbit),
        .txvalid   (txvalid),
        .busy      (busy),
        .txdone    (txdone),
        .epc_err   (epc_err)
    );

    always #5 txclk = ~txclk;

    // EPC source: index -1 means unprimed; the first enable loads the top index.
    logic [111:0] src;
    logic [111:0] src_sh;
    int           src_idx = -1;
    bit           force_low = 1'b0;

    always @(posedge txclk) begin
        if (epc_reset) src_idx <= -1;
        else if (epc_clk_en) src_idx <= (src_idx < 0) ? EPC_BITS - 1 : src_idx - 1;
    end

    always_comb begin
        src_sh    = (src_idx >= 0) ? (src >> src_idx) : 112'd0;
        epcbitin  = src_sh[0];
        epcdonein = epc_reset | ((src_idx == 0) & ~force_low);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input logic [111:0] s);
        logic [15:0]  c = 16'hFFFF;
        logic [111:0] t = s;
        logic         fb;
        for (int i = 0; i < EPC_BITS; i++) begin
            fb = c[15] ^ t[111];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
            t = {t[110:0], 1'b0};
        end
        return ~c;
    endfunction

    logic exp_q[$];

    task automatic build_exp(input bit is_epc, input logic [15:0] rn, input logic [111:0] s);
        logic [5:0]   p = PREAMBLE;
        logic [15:0]  r = rn;
        logic [111:0] t = s;
        logic [15:0]  c = crc_model(s);
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(p[5]);
            p = {p[4:0], 1'b0};
        end
        if (is_epc) begin
            for (int i = 0; i < EPC_BITS; i++) begin
                exp_q.push_back(t[111]);
                t = {t[110:0], 1'b0};
            end
            for (int i = 0; i < 16; i++) begin
                exp_q.push_back(c[15]);
                c = {c[14:0], 1'b0};
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                exp_q.push_back(r[15]);
                r = {r[14:0], 1'b0};
            end
        end
        exp_q.push_back(1'b1);
    endtask

    function automatic logic [6:0] outs();
        return {txbit, txvalid, busy, txdone, epc_clk_en, epc_reset, epc_err};
    endfunction

    // Called at a negedge with the DUT idle. abort_at/reset_at (valid-bit counts) < 0 disable.
    task automatic run_reply(input string tag, input bit do_epc, input bit do_rn,
                             input logic [15:0] rn, input int abort_at, input int reset_at,
                             input bit intrude);
        int vcnt = 0, idle = 0, prime = 0, ens = 0, nbad = 0, done = 0, cyc = 0;
        bit seen = 1'b0, stop = 1'b0, ab_pend = 1'b0, rst_hit = 1'b0;
        build_exp(do_epc, rn, src);
        req_epc  = do_epc;
        req_rn16 = do_rn;
        rn16     = rn;
        #1;
        if (do_epc) check_eq({tag, ".rst_drop"}, 32'(epc_reset), 32'd0);
        @(negedge txclk);
        req_epc  = 1'b0;
        req_rn16 = 1'b0;
        rn16     = 16'($urandom);
        while (!stop && cyc < 400) begin
            req_rn16 = 1'b0;
            if (ab_pend) begin
                check_eq({tag, ".post_abort"}, 32'({busy, txvalid, txdone, epc_reset}), 32'h1);
                abort   = 1'b0;
                ab_pend = 1'b0;
            end
            if (txvalid) begin
                if (vcnt >= exp_q.size() || txbit !== exp_q[vcnt]) nbad++;
                vcnt++;
                seen = 1'b1;
            end else if (!seen && busy) begin
                idle++;
            end
            if (!seen && epc_clk_en) prime++;
            if (epc_clk_en) ens++;
            if (txdone) done++;
            if (seen && !busy) stop = 1'b1;
            if (!stop && txvalid && vcnt == abort_at) begin
                abort   = 1'b1;
                ab_pend = 1'b1;
            end
            if (intrude && txvalid && vcnt == 10) req_rn16 = 1'b1;
            if (!stop && txvalid && vcnt == reset_at) begin
                reset_n = 1'b0;
                #1;
                check_eq({tag, ".async_rst"}, 32'(outs()), 32'h02);
                repeat (2) @(negedge txclk);
                reset_n = 1'b1;
                stop    = 1'b1;
                rst_hit = 1'b1;
            end
            if (!stop) begin
                @(negedge txclk);
                cyc++;
            end
        end
        check_eq({tag, ".timeout"}, 32'(cyc >= 400), 32'd0);
        check_eq({tag, ".bits"}, 32'(nbad), 32'd0);
        if (rst_hit) begin
            check_eq({tag, ".rst_done"}, 32'(done), 32'd0);
        end else if (abort_at >= 0) begin
            check_eq({tag, ".abort_vcnt"}, 32'(vcnt), 32'(abort_at));
            check_eq({tag, ".abort_done"}, 32'(done), 32'd0);
        end else begin
            check_eq({tag, ".vcnt"}, 32'(vcnt), 32'(exp_q.size()));
            check_eq({tag, ".done"}, 32'(done), 32'd1);
            check_eq({tag, ".t1"}, 32'(idle), 32'(T1_CYCLES));
            if (do_epc) begin
                check_eq({tag, ".prime"}, 32'(prime), 32'd1);
                check_eq({tag, ".clk_en"}, 32'(ens), 32'(EPC_BITS));
            end
        end
        @(negedge txclk);
    endtask

    task automatic new_src();
        logic [127:0] w = {$urandom(), $urandom(), $urandom(), $urandom()};
        src = w[111:0];
    endtask

    initial begin
        bit busy_seen;
        reset_n  = 1'b0;
        req_rn16 = 1'b0;
        req_epc  = 1'b0;
        abort    = 1'b0;
        rn16     = 16'h0000;
        src      = 112'h3000aabbccddeeff012345678910;
        repeat (3) @(negedge txclk);
        check_eq("reset_outs", 32'(outs()), 32'h02);
        reset_n = 1'b1;
        @(negedge txclk);

        run_reply("rn16_a5c3", 1'b0, 1'b1, 16'hA5C3, -1, -1, 1'b0);
        check_eq("rn16_len", 32'(exp_q.size()), 32'd23);

        run_reply("epc_fixed", 1'b1, 1'b0, 16'h0000, -1, -1, 1'b0);
        check_eq("epc_len", 32'(exp_q.size()), 32'd135);
        check_eq("epc_err0", 32'(epc_err), 32'd0);

        // Both requests: EPC must win; an RN16 request mid-reply must not be queued.
        new_src();
        run_reply("both_req", 1'b1, 1'b1, 16'h1234, -1, -1, 1'b1);
        busy_seen = 1'b0;
        repeat (5) begin
            if (busy) busy_seen = 1'b1;
            @(negedge txclk);
        end
        check_eq("no_queue", 32'(busy_seen), 32'd0);

        // Abort in IDLE overrides a simultaneous request.
        abort    = 1'b1;
        req_rn16 = 1'b1;
        @(negedge txclk);
        abort    = 1'b0;
        req_rn16 = 1'b0;
        check_eq("idle_abort", 32'(busy), 32'd0);
        @(negedge txclk);

        new_src();
        run_reply("epc_abort", 1'b1, 1'b0, 16'h0000, 57, -1, 1'b0);
        run_reply("rn16_after_abort", 1'b0, 1'b1, 16'($urandom), -1, -1, 1'b0);

        new_src();
        force_low = 1'b1;
        run_reply("epc_forced", 1'b1, 1'b0, 16'h0000, -1, -1, 1'b0);
        force_low = 1'b0;
        check_eq("err_set", 32'(epc_err), 32'd1);
        run_reply("rn16_err_hold", 1'b0, 1'b1, 16'($urandom), -1, -1, 1'b0);
        check_eq("err_sticky", 32'(epc_err), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("err_cleared", 32'(epc_err), 32'd0);
        @(negedge txclk);
        reset_n = 1'b1;
        @(negedge txclk);

        new_src();
        run_reply("epc_rst_crc", 1'b1, 1'b0, 16'h0000, -1, 6 + EPC_BITS + 5, 1'b0);
        new_src();
        run_reply("epc_after_rst", 1'b1, 1'b0, 16'h0000, -1, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            bit is_epc = 1'($urandom);
            new_src();
            run_reply($sformatf("rand%0d", i), is_epc, ~is_epc | 1'($urandom),
                      16'($urandom), -1, -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
